// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;

  // An all-zero word terminates the program.
  localparam logic [INSTR_W-1:0] NOP_HALT_WORD = '0;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StHalt,
    StTrap
  } fetch_state_e;

  // One prefetch entry: the fetch address and the word returned for it.
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of {pc, instr} entries with push/pop/flush.
// Depth must be a power of two so the pointers wrap naturally.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         push_i,
  input  fetch_entry_t                 wdata_i,
  input  logic                         pop_i,
  output fetch_entry_t                 rdata_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  fetch_entry_t    mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] count_q;

  // Pointers and occupancy; a flush discards any same-cycle push or pop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Entry storage needs no reset: the head is masked to zero while empty.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Status and head outputs.
  always_comb begin
    full_o  = (count_q == CntW'(Depth));
    empty_o = (count_q == '0);
    count_o = count_q;
    rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
  end

endmodule

// File: rtl/instruction_fetch_controller.sv
// Instruction fetch controller: owns the PC, fetches from a combinational
// program memory into a prefetch FIFO and presents {pc, instr} to decode.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect traps).
module instruction_fetch_controller
  import fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0,
  parameter int unsigned       FIFO_DEPTH = 2,
  parameter int unsigned       MEM_BYTES  = 1001
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               Start,
  output logic [ADDR_W-1:0]  Counter_value,
  input  logic [INSTR_W-1:0] Instruction_code,
  input  logic               Redirect_valid,
  input  logic [ADDR_W-1:0]  Redirect_target,
  output logic               Inst_valid,
  input  logic               Inst_ready,
  output logic [INSTR_W-1:0] Inst_data,
  output logic [ADDR_W-1:0]  Inst_pc,
  output logic               Halted,
  output logic               Trap
);

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] pc_q;
  logic              halted_q;

  logic                               redirect_take;
  logic                               redirect_bad;
  logic [ADDR_W-1:0]                  redirect_pc;
  logic                               fetch_legal;
  logic                               word_ok;
  logic                               fetching;
  logic                               fifo_push;
  logic                               fifo_pop;
  logic                               fifo_full;
  logic                               fifo_empty;
  logic                               fetch_stop;
  fetch_entry_t                       fifo_wdata;
  fetch_entry_t                       fifo_head;
  logic [$clog2(FIFO_DEPTH+1)-1:0]    unused_fifo_count;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic trap_q;
  assign redirect_pc  = Redirect_target;
  assign redirect_bad = |Redirect_target[1:0];
  assign Trap         = trap_q;
`else
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^Redirect_target[1:0];
  assign redirect_pc        = {Redirect_target[ADDR_W-1:2], 2'b00};
  assign redirect_bad       = 1'b0;
  assign Trap               = 1'b0;
`endif

  // Fetch qualification, FIFO handshakes and redirect priority.
  always_comb begin
    redirect_take = Redirect_valid && (state_q != StIdle);
    // 33-bit sum so a wrapped address can never pass the range check.
    fetch_legal   = ({1'b0, pc_q} + 33'd3) <= 33'(MEM_BYTES - 1);
    word_ok       = (Instruction_code != NOP_HALT_WORD);
    fetching      = (state_q == StFetch) && !redirect_take;
    fifo_pop      = !fifo_empty && Inst_ready && !redirect_take;
    fifo_push     = fetching && fetch_legal && word_ok && (!fifo_full || fifo_pop);
    fetch_stop    = fetching && !(fetch_legal && word_ok);
    fifo_wdata    = '{pc: pc_q, instr: Instruction_code};
  end

  // FSM, PC and registered status flags.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      halted_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      trap_q   <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (Start) begin
            state_q <= StFetch;
            pc_q    <= RESET_PC;
          end
        end
        StFetch, StHalt, StTrap: begin
          if (redirect_take) begin
            if (redirect_bad) begin
              state_q  <= StTrap;
              halted_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
              trap_q   <= 1'b1;
`endif
            end else begin
              state_q  <= StFetch;
              pc_q     <= redirect_pc;
              halted_q <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
              trap_q   <= 1'b0;
`endif
            end
          end else if (fifo_push) begin
            pc_q <= pc_q + 32'd4;
          end else if (fetch_stop) begin
            state_q  <= StHalt;
            halted_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  fetch_fifo #(
    .Depth (FIFO_DEPTH)
  ) u_fetch_fifo (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .flush_i (redirect_take),
    .push_i  (fifo_push),
    .wdata_i (fifo_wdata),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (unused_fifo_count)
  );

  assign Counter_value = pc_q;
  assign Inst_valid    = !fifo_empty;
  assign Inst_data     = fifo_head.instr;
  assign Inst_pc       = fifo_head.pc;
  assign Halted        = halted_q;

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Scoreboard bench for instruction_fetch_controller.
module tb_instruction_fetch_controller;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        inst_ready = 1'b0;
  logic [31:0] counter_value, instr_code, inst_data, inst_pc;
  logic        inst_valid, halted, trap;

  // Second instance with a tiny memory for the range boundary.
  logic        start2 = 1'b0;
  logic        ready2 = 1'b0;
  logic        redirect2 = 1'b0;
  logic [31:0] target2 = 32'h0;
  logic [31:0] counter_value2, instr_code2, inst_data2, inst_pc2;
  logic        inst_valid2, halted2, trap2;

  logic [31:0] prog [0:15];
  logic [63:0] sb_q [$];
  logic [63:0] sb2_q [$];
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  assign instr_code  = (counter_value < 32'd64) ? prog[counter_value[5:2]] : 32'hDEADBEEF;
  assign instr_code2 = {16'hA5A5, counter_value2[15:0]} | 32'h1;

  instruction_fetch_controller dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .Start            (start),
    .Counter_value    (counter_value),
    .Instruction_code (instr_code),
    .Redirect_valid   (redirect_valid),
    .Redirect_target  (redirect_target),
    .Inst_valid       (inst_valid),
    .Inst_ready       (inst_ready),
    .Inst_data        (inst_data),
    .Inst_pc          (inst_pc),
    .Halted           (halted),
    .Trap             (trap)
  );

  instruction_fetch_controller #(
    .MEM_BYTES (8)
  ) dut_small (
    .clk              (clk),
    .reset_n          (reset_n),
    .Start            (start2),
    .Counter_value    (counter_value2),
    .Instruction_code (instr_code2),
    .Redirect_valid   (redirect2),
    .Redirect_target  (target2),
    .Inst_valid       (inst_valid2),
    .Inst_ready       (ready2),
    .Inst_data        (inst_data2),
    .Inst_pc          (inst_pc2),
    .Halted           (halted2),
    .Trap             (trap2)
  );

  initial begin
    prog[0]  = 32'h06400293;  prog[1]  = 32'h00008113;
    prog[2]  = 32'h00500193;  prog[3]  = 32'h00A00213;
    prog[4]  = 32'h002181B3;  prog[5]  = 32'h40208233;
    prog[6]  = 32'h0041F2B3;  prog[7]  = 32'h0051E333;
    prog[8]  = 32'h00628463;  prog[9]  = 32'h00C00367;
    prog[10] = 32'h00000000;
    for (int i = 11; i < 16; i++) prog[i] = 32'hFFFFFFFF;
  end

  task automatic expect_words(input int first, input int last);
    for (int i = first; i <= last; i++) sb_q.push_back({32'(i * 4), prog[i]});
  endtask

  // Drain with ready held high, comparing every accepted head to the scoreboard.
  task automatic consume(input int budget, input string tag);
    int          cyc;
    logic [63:0] exp;
    cyc = 0;
    inst_ready = 1'b1;
    while ((sb_q.size() != 0 || !halted || inst_valid) && cyc < budget) begin
      if (inst_valid) begin
        n_checks++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s extra: got pc=%h data=%h, required no entry", tag, inst_pc, inst_data);
        end else begin
          exp = sb_q.pop_front();
          if ({inst_pc, inst_data} !== exp) begin
            n_fail++;
            $display("FAIL %s entry: got pc=%h data=%h, required pc=%h data=%h",
                     tag, inst_pc, inst_data, exp[63:32], exp[31:0]);
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    n_checks++;
    if (sb_q.size() != 0 || !halted || inst_valid) begin
      n_fail++;
      $display("FAIL %s drain: got %0d pending halted=%b valid=%b, required 0 pending halted=1",
               tag, sb_q.size(), halted, inst_valid);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; start = 1'b0; redirect_valid = 1'b0; inst_ready = 1'b0;
    start2 = 1'b0; ready2 = 1'b0;
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    sb_q.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1; @(negedge clk); start = 1'b0;
  endtask

  task automatic pulse_redirect(input logic [31:0] t);
    redirect_valid = 1'b1; redirect_target = t; @(negedge clk); redirect_valid = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    n_checks++; if (counter_value !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h, required 0", counter_value); end
    n_checks++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", inst_valid); end
    n_checks++; if (inst_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h, required 0", inst_data); end
    n_checks++; if (inst_pc !== 32'h0) begin n_fail++; $display("FAIL reset_ipc: got %h, required 0", inst_pc); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %b, required 0", halted); end
    n_checks++; if (trap !== 1'b0) begin n_fail++; $display("FAIL reset_trap: got %b, required 0", trap); end
    do_reset();
  endtask

  task automatic test_stream();
    do_reset();
    pulse_start();
    expect_words(0, 9);
    consume(60, "stream");
    n_checks++; if (counter_value !== 32'd40) begin n_fail++; $display("FAIL stream_halt_pc: got %h, required 28", counter_value); end
  endtask

  task automatic test_backpressure();
    do_reset();
    pulse_start();
    repeat (6) @(negedge clk);
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin n_fail++; $display("FAIL bp_head: got valid=%b pc=%h, required 1 0", inst_valid, inst_pc); end
    n_checks++; if (counter_value !== 32'd8) begin n_fail++; $display("FAIL bp_frozen: got %h, required 8", counter_value); end
    expect_words(0, 9);
    consume(60, "bp");
  endtask

  task automatic test_redirect_full();
    do_reset();
    pulse_start();
    repeat (4) @(negedge clk);
    n_checks++; if (counter_value !== 32'd8) begin n_fail++; $display("FAIL rf_full_pc: got %h, required 8", counter_value); end
    pulse_redirect(32'h10);
    n_checks++; if (inst_valid !== 1'b0 || counter_value !== 32'h10) begin n_fail++; $display("FAIL rf_flush: got valid=%b pc=%h, required 0 10", inst_valid, counter_value); end
    @(negedge clk);
    n_checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h10 || inst_data !== 32'h002181B3) begin
      n_fail++; $display("FAIL rf_first: got valid=%b pc=%h data=%h, required 1 10 002181b3", inst_valid, inst_pc, inst_data);
    end
    expect_words(4, 9);
    consume(60, "redirect");
  endtask

  task automatic test_halt_redirect();
    pulse_start();
    n_checks++; if (halted !== 1'b1 || counter_value !== 32'd40) begin n_fail++; $display("FAIL hr_start_ignored: got halted=%b pc=%h, required 1 28", halted, counter_value); end
    pulse_redirect(32'h1C);
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL hr_resume: got halted=%b, required 0", halted); end
    expect_words(7, 9);
    consume(40, "halt_redirect");
  endtask

  task automatic test_small_mem();
    int          cyc;
    logic [63:0] exp;
    do_reset();
    sb2_q.push_back({32'h0, 32'hA5A50001});
    sb2_q.push_back({32'h4, 32'hA5A50005});
    start2 = 1'b1; @(negedge clk); start2 = 1'b0;
    ready2 = 1'b1;
    cyc = 0;
    while ((sb2_q.size() != 0 || !halted2 || inst_valid2) && cyc < 30) begin
      if (inst_valid2) begin
        n_checks++;
        if (sb2_q.size() == 0) begin
          n_fail++; $display("FAIL small extra: got pc=%h, required no entry", inst_pc2);
        end else begin
          exp = sb2_q.pop_front();
          if ({inst_pc2, inst_data2} !== exp) begin
            n_fail++; $display("FAIL small entry: got %h %h, required %h %h", inst_pc2, inst_data2, exp[63:32], exp[31:0]);
          end
        end
      end
      @(negedge clk);
      cyc++;
    end
    n_checks++; if (halted2 !== 1'b1 || counter_value2 !== 32'd8 || sb2_q.size() != 0) begin
      n_fail++; $display("FAIL small_halt: got halted=%b pc=%h pending=%0d, required 1 8 0", halted2, counter_value2, sb2_q.size());
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    pulse_start();
    inst_ready = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++; if (counter_value !== 32'h0 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL async_pc_valid: got %h %b, required 0 0", counter_value, inst_valid); end
    n_checks++; if (inst_pc !== 32'h0 || inst_data !== 32'h0 || halted !== 1'b0) begin
      n_fail++; $display("FAIL async_outs: got %h %h %b, required 0 0 0", inst_pc, inst_data, halted);
    end
    @(negedge clk);
    reset_n = 1'b1;
    inst_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_misalign();
    do_reset();
    pulse_start();
    repeat (2) @(negedge clk);
    pulse_redirect(32'h6);
`ifdef FETCH_MISALIGN_TRAP_EN
    n_checks++; if (trap !== 1'b1 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL mis_trap: got trap=%b valid=%b, required 1 0", trap, inst_valid); end
    repeat (3) @(negedge clk);
    n_checks++; if (inst_valid !== 1'b0 || halted !== 1'b0) begin n_fail++; $display("FAIL mis_hold: got valid=%b halted=%b, required 0 0", inst_valid, halted); end
    pulse_redirect(32'h0);
    n_checks++; if (trap !== 1'b0) begin n_fail++; $display("FAIL mis_exit: got trap=%b, required 0", trap); end
    expect_words(0, 9);
    consume(60, "misalign");
`else
    n_checks++; if (trap !== 1'b0 || counter_value !== 32'h4) begin n_fail++; $display("FAIL mis_align: got trap=%b pc=%h, required 0 4", trap, counter_value); end
    expect_words(1, 9);
    consume(60, "misalign");
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_halt_redirect();
    test_small_mem();
    test_async_reset();
    test_misalign();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
